// File: rtl/if_stage_if.sv
// IF-stage bus: instruction-memory port plus the IF/ID pipeline register outputs.
// The master modport is the fetch stage; the slave modport is the ROM/decode side.
interface if_stage_if;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_inst_i;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc4_o;
  logic        id_valid_o;
  logic        id_fault_o;
  logic [31:0] fetch_cnt_o;

  modport master (
    output imem_addr_o,
    input  imem_inst_i,
    output id_inst_o,
    output id_pc_o,
    output id_pc4_o,
    output id_valid_o,
    output id_fault_o,
    output fetch_cnt_o
  );

  modport slave (
    input  imem_addr_o,
    output imem_inst_i,
    input  id_inst_o,
    input  id_pc_o,
    input  id_pc4_o,
    input  id_valid_o,
    input  id_fault_o,
    input  fetch_cnt_o
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, ROM-window fault check and IF/ID register
// with stall, flush and branch/jump redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 2048,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  if_stage_if.master  bus
);

  localparam logic [31:0] PC_LAST = RESET_PC + 32'(4 * IM_WORDS) - 32'd4;

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] pc4_c;
  logic        fault_c;

  assign pc4_c   = pc_q + 32'd4;
  assign fault_c = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) || (pc_q > PC_LAST);

  always_comb begin
    pc_d     = pc_q;
    inst_d   = inst_q;
    id_pc_d  = id_pc_q;
    id_pc4_d = id_pc4_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;

    // Redirect beats stall so a branch resolved while stalled is never dropped.
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (!stall_i) begin
      pc_d = pc4_c;
    end

    // The slot fetched alongside a redirect is the delay slot and is kept.
    if (flush_i) begin
      inst_d  = NOP_WORD;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (stall_i) begin
      inst_d = inst_q;
    end else if (fault_c) begin
      inst_d   = NOP_WORD;
      id_pc_d  = pc_q;
      id_pc4_d = pc4_c;
      valid_d  = 1'b0;
      fault_d  = 1'b1;
    end else begin
      inst_d   = bus.imem_inst_i;
      id_pc_d  = pc_q;
      id_pc4_d = pc4_c;
      valid_d  = 1'b1;
      fault_d  = 1'b0;
      cnt_d    = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      inst_q   <= NOP_WORD;
      id_pc_q  <= 32'd0;
      id_pc4_q <= 32'd0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= 32'd0;
    end else begin
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      id_pc_q  <= id_pc_d;
      id_pc4_q <= id_pc4_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.imem_addr_o = pc_q;
  assign bus.id_inst_o   = inst_q;
  assign bus.id_pc_o     = id_pc_q;
  assign bus.id_pc4_o    = id_pc4_q;
  assign bus.id_valid_o  = valid_q;
  assign bus.id_fault_o  = fault_q;
  assign bus.fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: driver pushes hand-computed post-edge state,
// monitor pops and compares one edge later against a ROM model driven by the bench.
module tb_if_stage;

  localparam int unsigned IM_WORDS = 2048;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        fault;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  logic [31:0] rom [IM_WORDS];
  logic [31:0] rom_off;

  exp_t sb [$];
  int   tests = 0;
  int   fails = 0;

  if_stage_if bus ();

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .bus           (bus.master)
  );

  always #5 clk = ~clk;

  // Combinational ROM; out-of-window reads return garbage that must never reach IF/ID.
  always_comb begin
    rom_off = bus.imem_addr_o - 32'h0000_3000;
    if (bus.imem_addr_o >= 32'h0000_3000 && bus.imem_addr_o <= 32'h0000_4FFC)
      bus.imem_inst_i = rom[rom_off[12:2]];
    else
      bus.imem_inst_i = 32'hDEAD_BEEF;
  end

  task automatic step(input string name, input logic r, input logic s, input logic f,
                      input logic rd, input logic [31:0] rpc,
                      input logic [31:0] e_addr, input logic [31:0] e_inst,
                      input logic [31:0] e_pc, input logic [31:0] e_pc4,
                      input logic e_v, input logic e_f, input logic [31:0] e_cnt);
    exp_t e;
    @(negedge clk);
    rst_n         = r;
    stall_i       = s;
    flush_i       = f;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    e.name = name; e.addr = e_addr; e.inst = e_inst; e.pc = e_pc; e.pc4 = e_pc4;
    e.valid = e_v; e.fault = e_f; e.cnt = e_cnt;
    sb.push_back(e);
  endtask

  // Monitor: every edge that has a pending expectation is checked just after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (bus.imem_addr_o !== e.addr || bus.id_inst_o !== e.inst || bus.id_pc_o !== e.pc ||
          bus.id_pc4_o !== e.pc4 || bus.id_valid_o !== e.valid || bus.id_fault_o !== e.fault ||
          bus.fetch_cnt_o !== e.cnt) begin
        fails++;
        $display("FAIL %s: got addr=%h inst=%h pc=%h pc4=%h v=%b f=%b cnt=%0d, want addr=%h inst=%h pc=%h pc4=%h v=%b f=%b cnt=%0d",
                 e.name, bus.imem_addr_o, bus.id_inst_o, bus.id_pc_o, bus.id_pc4_o,
                 bus.id_valid_o, bus.id_fault_o, bus.fetch_cnt_o,
                 e.addr, e.inst, e.pc, e.pc4, e.valid, e.fault, e.cnt);
      end
    end
  end

  initial begin
    for (int i = 0; i < int'(IM_WORDS); i++) rom[i] = 32'h2408_0001 + 32'(i);
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;

    //   name          rst  st  fl  rd  target        addr          inst          pc            pc4           v  f  cnt
    step("reset",      0, 0, 0, 0, 32'h0,        32'h3000,     32'h0,        32'h0,        32'h0,        0, 0, 0);
    step("run1",       1, 0, 0, 0, 32'h0,        32'h3004,     32'h24080001, 32'h3000,     32'h3004,     1, 0, 1);
    step("run2",       1, 0, 0, 0, 32'h0,        32'h3008,     32'h24080002, 32'h3004,     32'h3008,     1, 0, 2);
    step("stall1",     1, 1, 0, 0, 32'h0,        32'h3008,     32'h24080002, 32'h3004,     32'h3008,     1, 0, 2);
    step("stall2",     1, 1, 0, 0, 32'h0,        32'h3008,     32'h24080002, 32'h3004,     32'h3008,     1, 0, 2);
    step("resume1",    1, 0, 0, 0, 32'h0,        32'h300C,     32'h24080003, 32'h3008,     32'h300C,     1, 0, 3);
    step("resume2",    1, 0, 0, 0, 32'h0,        32'h3010,     32'h24080004, 32'h300C,     32'h3010,     1, 0, 4);
    step("redir_ds",   1, 0, 0, 1, 32'h3040,     32'h3040,     32'h24080005, 32'h3010,     32'h3014,     1, 0, 5);
    step("redir_tgt",  1, 0, 0, 0, 32'h0,        32'h3044,     32'h24080011, 32'h3040,     32'h3044,     1, 0, 6);
    step("redir_back", 1, 0, 0, 1, 32'h3010,     32'h3010,     32'h24080012, 32'h3044,     32'h3048,     1, 0, 7);
    step("redir_stl",  1, 1, 0, 1, 32'h3080,     32'h3080,     32'h24080012, 32'h3044,     32'h3048,     1, 0, 7);
    step("flush_stl",  1, 1, 1, 0, 32'h0,        32'h3080,     32'h0,        32'h3044,     32'h3048,     0, 0, 7);
    step("after_fl",   1, 0, 0, 0, 32'h0,        32'h3084,     32'h24080021, 32'h3080,     32'h3084,     1, 0, 8);
    step("redir_oow",  1, 0, 0, 1, 32'h5000,     32'h5000,     32'h24080022, 32'h3084,     32'h3088,     1, 0, 9);
    step("fault_oow",  1, 0, 0, 1, 32'h3002,     32'h3002,     32'h0,        32'h5000,     32'h5004,     0, 1, 9);
    step("fault_mis",  1, 0, 0, 1, 32'h4FFC,     32'h4FFC,     32'h0,        32'h3002,     32'h3006,     0, 1, 9);
    step("last_word",  1, 0, 0, 0, 32'h0,        32'h5000,     32'h24080800, 32'h4FFC,     32'h5000,     1, 0, 10);
    step("past_end",   1, 0, 0, 0, 32'h0,        32'h5004,     32'h0,        32'h5000,     32'h5004,     0, 1, 10);
    step("redir_low",  1, 0, 0, 1, 32'h2FFC,     32'h2FFC,     32'h0,        32'h5004,     32'h5008,     0, 1, 10);
    step("below_win",  1, 0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h2FFC,     32'h3000,     0, 1, 10);
    step("pc_wrap",    1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'hFFFFFFFC, 32'h0,        0, 1, 10);
    step("flush_flt",  1, 0, 1, 0, 32'h0,        32'h4,        32'h0,        32'hFFFFFFFC, 32'h0,        0, 0, 10);
    step("redir_home", 1, 0, 0, 1, 32'h3000,     32'h3000,     32'h0,        32'h4,        32'h8,        0, 1, 10);
    step("home_fetch", 1, 0, 0, 0, 32'h0,        32'h3004,     32'h24080001, 32'h3000,     32'h3004,     1, 0, 11);
    step("mid_reset",  0, 1, 1, 1, 32'h3040,     32'h3000,     32'h0,        32'h0,        32'h0,        0, 0, 0);
    step("post_reset", 1, 0, 0, 0, 32'h0,        32'h3004,     32'h24080001, 32'h3000,     32'h3004,     1, 0, 1);

    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
